dm_wait_resp: RTL and testbench

Multi-cycle data-memory responder sitting on the processor's data-memory port (dm_addr, dm_read, dm_write, dm_wrt_data, dm_rd_data). It replaces the zero-wait data memory with one that answers after a programmable latency. It drives a busy signal that the top level wires to the PC `hold` input, so the single-cycle core freezes until the access completes. Word-addressed, 16-bit data, one outstanding access.

---
 rtl/dm_pkg.sv | 18 +
 rtl/mem_array_1rw.sv | 35 +++
 rtl/dm_wait_resp.sv | 141 ++++++++++++++
 tb/tb_dm_wait_resp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
//   dm_state_e : responder FSM states
//   DM_LAT_MAX : largest supported LATENCY
//   DM_CNT_W   : width of the wait-cycle counter
//   DM_RD_OOR  : data returned by an out-of-range read
package dm_pkg;

  localparam int unsigned DM_LAT_MAX = 15;
  localparam int unsigned DM_CNT_W   = 4;
  localparam logic [15:0] DM_RD_OOR  = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } dm_state_e;

endpackage

// File: rtl/mem_array_1rw.sv
// Synchronous single-port 16-bit memory, one access per cycle.
//   clk_i   : rising-edge clock
//   we_i    : write enable, wdata_i stored at addr_i
//   re_i    : read enable, rdata_o loads the word at addr_i
//   addr_i  : word index (caller guarantees < Depth when enabled)
//   wdata_i : write data
//   rdata_o : registered read data, held between reads
module mem_array_1rw #(
  parameter int unsigned Depth = 4096,
  parameter int unsigned AddrW = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [15:0]      wdata_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [Depth];
  logic [15:0] rdata_q;

  // Contents and read register deliberately have no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_wait_resp.sv
// Multi-cycle data-memory responder. Accepts one read or write, stalls the
// core via busy_o for LATENCY+1 cycles, then completes in a one-cycle DONE.
//   clk_i      : rising-edge clock
//   rst_ni     : asynchronous active-low reset
//   addr_i     : word address from the core
//   re_i/we_i  : read / write request (both high is illegal)
//   wrt_data_i : write data
//   rd_data_o  : read data, valid with rd_valid_o, held otherwise
//   rd_valid_o : one-cycle read completion pulse
//   busy_o     : stall request (PC hold)
//   err_o      : one-cycle pulse for out-of-range or illegal requests
module dm_wait_resp
  import dm_pkg::*;
#(
  parameter int unsigned LATENCY = 2,    // legal range 1..DM_LAT_MAX
  parameter int unsigned DEPTH   = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] addr_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [15:0] wrt_data_i,
  output logic [15:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dm_state_e             state_q, state_d;
  logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]           addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ill_q, ill_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q, err_d;
  logic                  rd_zero_q, rd_zero_d;

  logic                  oor;
  logic                  do_access;
  logic                  mem_we, mem_re;
  logic [15:0]           mem_rdata;

  assign oor       = ({16'h0000, addr_q} >= DEPTH);
  assign do_access = (state_q == StWait) && (cnt_q == '0);
  assign mem_we    = do_access & wr_q & ~oor;
  assign mem_re    = do_access & rd_q & ~oor;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ill_d      = ill_q;
    rd_zero_d  = rd_zero_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (re_i | we_i) begin
          addr_d  = addr_i;
          wdata_d = wrt_data_i;
          rd_d    = re_i & ~we_i;
          wr_d    = we_i & ~re_i;
          ill_d   = re_i & we_i;
          cnt_d   = DM_CNT_W'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rd_valid_d = rd_q;
          err_d      = ill_q | oor;
          // An out-of-range read reports DM_RD_OOR until the next good read.
          if (rd_q) begin
            rd_zero_d = oor;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // re/we here still belong to the instruction that just completed.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ill_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ill_q      <= ill_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  mem_array_1rw #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q[AddrW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Reset gating keeps busy low while held in reset even with a request pending.
  assign busy_o     = rst_ni & (((state_q == StIdle) & (re_i | we_i)) | (state_q == StWait));
  assign rd_data_o  = rd_zero_q ? DM_RD_OOR : mem_rdata;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_dm_wait_resp.sv
module tb_dm_wait_resp;

  localparam int LAT = 2;

  typedef struct {
    logic        rdv;
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [15:0] addr, wdata, rd_data;
  logic        rd_valid, busy, err;

  logic [1:0]  s_re, s_we, s_busy, s_rdv, s_err;
  logic [15:0] s_addr [2];
  logic [15:0] s_wd   [2];
  logic [15:0] s_rd   [2];

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dm_wait_resp #(.LATENCY(LAT), .DEPTH(4096)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .re_i(re), .we_i(we),
    .wrt_data_i(wdata), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .busy_o(busy), .err_o(err)
  );

  dm_wait_resp #(.LATENCY(1), .DEPTH(4096)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(s_addr[0]), .re_i(s_re[0]), .we_i(s_we[0]),
    .wrt_data_i(s_wd[0]), .rd_data_o(s_rd[0]), .rd_valid_o(s_rdv[0]),
    .busy_o(s_busy[0]), .err_o(s_err[0])
  );

  dm_wait_resp #(.LATENCY(15), .DEPTH(4096)) u_l15 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(s_addr[1]), .re_i(s_re[1]), .we_i(s_we[1]),
    .wrt_data_i(s_wd[1]), .rd_data_o(s_rd[1]), .rd_valid_o(s_rdv[1]),
    .busy_o(s_busy[1]), .err_o(s_err[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse on the main DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rd_valid === 1'b1 || err === 1'b1)) begin
      if (q.size() == 0) begin
        check("unexpected_completion", {30'b0, rd_valid, err}, 32'h0);
      end else begin
        m = q.pop_front();
        check("sb_rd_valid", rd_valid, m.rdv);
        check("sb_err", err, m.err);
        check("sb_rd_data", rd_data, m.data);
      end
    end
  end

  // One access held by the core across the stall; optional input glitching in WAIT.
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic glitch,
                        input logic erdv, input logic eerr, input logic [15:0] edata);
    exp_t e;
    @(posedge clk); #1;
    re = r; we = w; addr = a; wdata = d;
    if (erdv || eerr) begin
      e.rdv = erdv; e.err = eerr; e.data = edata;
      q.push_back(e);
    end
    @(negedge clk); check("busy_accept", busy, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (glitch) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end
      @(negedge clk); check("busy_wait", busy, 1'b1);
    end
    @(posedge clk); #1;
    @(negedge clk); check("busy_done", busy, 1'b0);
    re = 1'b0; we = 1'b0;
  endtask

  task automatic sweep(input int s, input int exp_stall, input logic [15:0] val);
    int stall, rdv;
    logic done;
    @(posedge clk); #1;
    s_we[s] = 1'b1; s_addr[s] = 16'h0040; s_wd[s] = val;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!s_busy[s]) begin done = 1'b1; break; end
    end
    check("sweep_wr_timeout", done, 1'b1);
    s_we[s] = 1'b0;
    @(posedge clk); #1;
    s_re[s] = 1'b1;
    stall = 0; rdv = 0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_rdv[s]) rdv++;
      if (s_busy[s]) stall++;
      else begin done = 1'b1; break; end
    end
    s_re[s] = 1'b0;
    check("sweep_rd_timeout", done, 1'b1);
    check("sweep_rd_data", s_rd[s], val);
    repeat (3) begin
      @(negedge clk);
      if (s_rdv[s]) rdv++;
    end
    check("sweep_stall", stall, exp_stall);
    check("sweep_rdv_pulses", rdv, 1);
    check("sweep_rd_data_held", s_rd[s], val);
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    s_re = '0; s_we = '0;
    s_addr[0] = '0; s_addr[1] = '0; s_wd[0] = '0; s_wd[1] = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      re = 1'($urandom); we = 1'($urandom);
      addr = 16'($urandom); wdata = 16'($urandom);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rd_data", rd_data, 16'h0000);
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); check("idle_busy", busy, 1'b0);
    end

    // Write then read.
    access(0, 1, 16'h0000, 16'h1111, 0, 0, 0, 16'h0);
    access(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0);
    access(1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'hBEEF);
    access(0, 1, 16'h0020, 16'h7777, 0, 0, 0, 16'h0);

    // Out of range write and read; no alias into word 0.
    access(0, 1, 16'h1000, 16'hDEAD, 0, 0, 1, 16'hBEEF);
    access(1, 0, 16'h1000, 16'h0000, 0, 1, 1, 16'h0000);
    access(1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1111);

    // Illegal re=we=1: err only, rd_data held, memory untouched.
    access(1, 1, 16'h0010, 16'h5555, 0, 0, 1, 16'h1111);
    access(1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'hBEEF);
    access(1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1111);

    // Inputs changing during WAIT are ignored.
    access(0, 1, 16'h0030, 16'hA5A5, 1, 0, 0, 16'h0);
    access(1, 0, 16'h0030, 16'h0000, 1, 1, 0, 16'hA5A5);

    // Reset in the first WAIT cycle abandons the write.
    @(posedge clk); #1;
    we = 1'b1; addr = 16'h0020; wdata = 16'h1234;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    we = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("rst_wait_rd_data", rd_data, 16'h0000);
    access(1, 0, 16'h0020, 16'h0000, 0, 1, 0, 16'h7777);

    // Latency extremes.
    sweep(0, 2, 16'h0FF0);
    sweep(1, 16, 16'hF00F);

    repeat (3) @(negedge clk);
    check("sb_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
